// File: rtl/axi_ram_wr.sv
// AXI4 write-channel slave backed by a byte-strobed RAM, with a registered debug read port.
// Optional: define AXI_RAM_WR_WLAST_CHECK_EN to flag misplaced wlast with a SLVERR response.
module axi_ram_wr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int LANE_BITS = $clog2(STRB_WIDTH);
    localparam int WORD_BITS = ADDR_WIDTH - LANE_BITS;
    localparam int DEPTH     = 2 ** WORD_BITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [2:0] MAX_SIZE    = 3'(LANE_BITS);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            state_q, state_d;
    logic                  awReady_q, awReady_d;
    logic                  wReady_q, wReady_d;
    logic                  bValid_q, bValid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] dbgData_q;

    logic                  wrEn;
    logic                  lastErr;
    logic [2:0]            sizeEff;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH:0]   wrapBytes;
    logic [ADDR_WIDTH-1:0] wrapMask;
    logic [ADDR_WIDTH-1:0] incAddr;
    logic [ADDR_WIDTH-1:0] nextAddr;
    logic [WORD_BITS-1:0]  wordIdx;
    logic [WORD_BITS-1:0]  dbgIdx;

`ifdef AXI_RAM_WR_WLAST_CHECK_EN
    assign lastErr = s_axi_wlast != (cnt_q == 8'd0);
`else
    logic unusedWlast;
    assign lastErr     = 1'b0;
    assign unusedWlast = s_axi_wlast;
`endif

    generate
        if (LANE_BITS > 0) begin : gDbgLow
            logic unusedDbgLow;
            assign unusedDbgLow = ^dbg_addr[LANE_BITS-1:0];
        end
    endgenerate

    // Beats wider than the bus are clamped; WRAP keeps the upper address bits and wraps the window bits.
    always_comb begin
        sizeEff   = (size_q > MAX_SIZE) ? MAX_SIZE : size_q;
        incr      = ADDR_WIDTH'(1) << sizeEff;
        wrapBytes = ((ADDR_WIDTH + 1)'(len_q) + (ADDR_WIDTH + 1)'(1)) << sizeEff;
        wrapMask  = wrapBytes[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
        incAddr   = addr_q + incr;
        case (burst_q)
            BURST_FIXED: nextAddr = addr_q;
            BURST_WRAP:  nextAddr = (addr_q & ~wrapMask) | (incAddr & wrapMask);
            default:     nextAddr = incAddr;
        endcase
    end

    assign wordIdx = addr_q[ADDR_WIDTH-1:LANE_BITS];
    assign dbgIdx  = dbg_addr[ADDR_WIDTH-1:LANE_BITS];

    always_comb begin
        state_d   = state_q;
        awReady_d = awReady_q;
        wReady_d  = wReady_q;
        bValid_d  = bValid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        wrEn      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                awReady_d = 1'b1;
                if (awReady_q && s_axi_awvalid) begin
                    awReady_d = 1'b0;
                    wReady_d  = 1'b1;
                    state_d   = ST_BURST;
                    id_d      = s_axi_awid;
                    addr_d    = s_axi_awaddr;
                    len_d     = s_axi_awlen;
                    size_d    = s_axi_awsize;
                    burst_d   = s_axi_awburst;
                    cnt_d     = s_axi_awlen;
                    err_d     = 1'b0;
                end
            end
            ST_BURST: begin
                // The beat count, not wlast, decides where the burst ends.
                if (wReady_q && s_axi_wvalid) begin
                    wrEn  = 1'b1;
                    err_d = err_q | lastErr;
                    if (cnt_q == 8'd0) begin
                        wReady_d = 1'b0;
                        bValid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = err_d ? 2'b10 : 2'b00;
                        state_d  = ST_RESP;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        addr_d = nextAddr;
                    end
                end
            end
            ST_RESP: begin
                if (bValid_q && s_axi_bready) begin
                    bValid_d  = 1'b0;
                    awReady_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            bValid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'b00;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awReady_q <= awReady_d;
            wReady_q  <= wReady_d;
            bValid_q  <= bValid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // RAM contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (wrEn && s_axi_wstrb[i]) begin
                mem[wordIdx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbgData_q <= '0;
        end else begin
            dbgData_q <= mem[dbgIdx];
        end
    end

    assign s_axi_awready = awReady_q;
    assign s_axi_wready  = wReady_q;
    assign s_axi_bvalid  = bValid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign dbg_data      = dbgData_q;

endmodule

// File: tb/tb_axi_ram_wr.sv
// Self-checking bench for axi_ram_wr: directed scenarios plus random bursts against a byte-level RAM model.
// Honours AXI_RAM_WR_WLAST_CHECK_EN when deciding the expected write response.
module tb_axi_ram_wr;

    logic        clk;
    logic        rst;
    logic [7:0]  awid;
    logic [15:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] dbgAddr;
    logic [31:0] dbgData;

`ifdef AXI_RAM_WR_WLAST_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  refMem   [65536];
    bit          refValid [65536];
    logic [31:0] bData [256];
    logic [3:0]  bStrb [256];
    bit          bLast [256];
    int          touched[$];

    axi_ram_wr dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awid    (awid),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_awsize  (awsize),
        .s_axi_awburst (awburst),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bid     (bid),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .dbg_addr      (dbgAddr),
        .dbg_data      (dbgData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Byte address of beat k, straight from the AXI burst rules.
    function automatic logic [15:0] beatAddr(input logic [15:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst, input int k);
        int bytes, total, base, off;
        bytes = 1 << ((size > 3'd2) ? 2 : int'(size));
        total = (int'(len) + 1) * bytes;
        case (burst)
            2'b00:   return addr;
            2'b10: begin
                base = int'(addr) - (int'(addr) % total);
                off  = (int'(addr) - base + k * bytes) % total;
                return 16'(base + off);
            end
            default: return 16'((int'(addr) + k * bytes) % 65536);
        endcase
    endfunction

    task automatic modelWrite(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int word;
        word = int'(addr) >> 2;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                refMem[word * 4 + i]   = data[8*i +: 8];
                refValid[word * 4 + i] = 1'b1;
            end
        end
        touched.push_back(word);
    endtask

    task automatic readWord(input logic [15:0] addr, output logic [31:0] data);
        dbgAddr = addr;
        @(negedge clk);
        data = dbgData;
    endtask

    task automatic checkTouched();
        logic [31:0] obs, expv, mask;
        int word;
        while (touched.size() > 0) begin
            word = touched.pop_front();
            mask = '0;
            expv = '0;
            for (int i = 0; i < 4; i++) begin
                if (refValid[word * 4 + i]) begin
                    mask[8*i +: 8] = 8'hFF;
                    expv[8*i +: 8] = refMem[word * 4 + i];
                end
            end
            if (mask != 32'd0) begin
                readWord(16'(word * 4), obs);
                checkOutput($sformatf("ram_word_%04h", word * 4), obs & mask, expv);
            end
        end
    endtask

    task automatic checkDirect(input string tag, input logic [15:0] addr, input logic [31:0] expv);
        logic [31:0] obs;
        readWord(addr, obs);
        checkOutput(tag, obs, expv);
    endtask

    // One complete AW/W/B transaction; beats come from bData/bStrb/bLast. Called at a negedge.
    task automatic applyStimulus(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst, input int bDelay);
        int  c;
        bit  mism, wTimeout;
        mism     = 1'b0;
        wTimeout = 1'b0;
        awid     = id;
        awaddr   = addr;
        awlen    = len;
        awsize   = size;
        awburst  = burst;
        awvalid  = 1'b1;
        c = 0;
        while (awready !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        checkOutput("aw_wait", 64'(c < 100), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        checkOutput("wready_after_aw", 64'(wready), 64'd1);
        checkOutput("awready_in_burst", 64'(awready), 64'd0);
        for (int k = 0; k <= int'(len); k++) begin
            repeat ($urandom_range(0, 1)) begin
                wvalid = 1'b0;
                @(negedge clk);
            end
            wdata  = bData[k];
            wstrb  = bStrb[k];
            wlast  = bLast[k];
            wvalid = 1'b1;
            c = 0;
            while (wready !== 1'b1 && c < 50) begin
                @(negedge clk);
                c++;
            end
            if (c >= 50) wTimeout = 1'b1;
            modelWrite(beatAddr(addr, len, size, burst, k), bData[k], bStrb[k]);
            if (bLast[k] != (k == int'(len))) mism = 1'b1;
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        checkOutput("w_wait", 64'(wTimeout), 64'd0);
        checkOutput("bvalid", 64'(bvalid), 64'd1);
        checkOutput("bid", 64'(bid), 64'(id));
        checkOutput("bresp", 64'(bresp), (CHECK_EN && mism) ? 64'd2 : 64'd0);
        checkOutput("wready_after_last", 64'(wready), 64'd0);
        for (int d = 0; d < bDelay; d++) begin
            @(negedge clk);
            checkOutput("bvalid_hold", 64'(bvalid), 64'd1);
            checkOutput("bid_hold", 64'(bid), 64'(id));
            checkOutput("bresp_hold", 64'(bresp), (CHECK_EN && mism) ? 64'd2 : 64'd0);
            checkOutput("awready_hold", 64'(awready), 64'd0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checkOutput("bvalid_after_b", 64'(bvalid), 64'd0);
        checkOutput("awready_after_b", 64'(awready), 64'd1);
    endtask

    task automatic fillBeats(input int n, input logic [31:0] base, input logic [3:0] strb);
        for (int k = 0; k < n; k++) begin
            bData[k] = base + 32'(k);
            bStrb[k] = strb;
            bLast[k] = (k == n - 1);
        end
    endtask

    initial begin
        logic [7:0]  rId, rLen;
        logic [15:0] rAddr;
        logic [2:0]  rSize;
        logic [1:0]  rBurst;
        int          c;

        rst = 1'b1;
        {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
        {wdata, wstrb, wlast, wvalid, bready} = '0;
        dbgAddr = '0;
        #12;
        checkOutput("rst_awready", 64'(awready), 64'd0);
        checkOutput("rst_wready", 64'(wready), 64'd0);
        checkOutput("rst_bvalid", 64'(bvalid), 64'd0);
        checkOutput("rst_bid", 64'(bid), 64'd0);
        checkOutput("rst_bresp", 64'(bresp), 64'd0);
        checkOutput("rst_dbg", 64'(dbgData), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("awready_after_rst", 64'(awready), 64'd1);

        // wvalid while idle must not be taken
        wdata  = 32'hDEADBEEF;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        @(negedge clk);
        checkOutput("wready_idle", 64'(wready), 64'd0);
        wvalid = 1'b0;

        $display("[TB] INCR burst of four words");
        for (int k = 0; k < 4; k++) begin
            bData[k] = 32'h11111111 * 32'(k + 1);
            bStrb[k] = 4'hF;
            bLast[k] = (k == 3);
        end
        applyStimulus(8'h5A, 16'h0100, 8'd3, 3'd2, 2'b01, 0);
        checkTouched();
        checkDirect("incr_0x10C", 16'h010C, 32'h44444444);

        $display("[TB] strobed single beat");
        fillBeats(1, 32'hFFFFFFFF, 4'hF);
        applyStimulus(8'h01, 16'h0200, 8'd0, 3'd2, 2'b01, 0);
        fillBeats(1, 32'hAABBCCDD, 4'b0101);
        applyStimulus(8'h02, 16'h0200, 8'd0, 3'd2, 2'b01, 0);
        checkTouched();
        checkDirect("strobe_0x200", 16'h0200, 32'hFFBBFFDD);

        $display("[TB] WRAP burst");
        fillBeats(4, 32'd1, 4'hF);
        applyStimulus(8'h03, 16'h0308, 8'd3, 3'd2, 2'b10, 0);
        checkTouched();
        checkDirect("wrap_0x300", 16'h0300, 32'd3);
        checkDirect("wrap_0x304", 16'h0304, 32'd4);

        $display("[TB] FIXED burst and address rollover");
        fillBeats(3, 32'd7, 4'hF);
        applyStimulus(8'h04, 16'h0400, 8'd2, 3'd2, 2'b00, 0);
        checkTouched();
        checkDirect("fixed_0x400", 16'h0400, 32'd9);
        fillBeats(2, 32'hC0DE0000, 4'hF);
        applyStimulus(8'h05, 16'hFFFC, 8'd1, 3'd2, 2'b01, 0);
        checkTouched();
        checkDirect("rollover_0x000", 16'h0000, 32'hC0DE0001);

        $display("[TB] response back-pressure");
        fillBeats(2, 32'h55AA0000, 4'hF);
        applyStimulus(8'h66, 16'h0500, 8'd1, 3'd2, 2'b01, 5);
        checkTouched();

        $display("[TB] early wlast");
        fillBeats(4, 32'h0BAD0000, 4'hF);
        bLast[1] = 1'b1;
        bLast[3] = 1'b0;
        applyStimulus(8'h77, 16'h0700, 8'd3, 3'd2, 2'b01, 0);
        checkTouched();

        $display("[TB] reset in the middle of a burst");
        awid    = 8'h99;
        awaddr  = 16'h0600;
        awlen   = 8'd3;
        awsize  = 3'd2;
        awburst = 2'b01;
        awvalid = 1'b1;
        c = 0;
        while (awready !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        checkOutput("aw_wait_rst", 64'(c < 100), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checkOutput("wready_pre_rst", 64'(wready), 64'd1);
            wdata  = 32'h60600000 + 32'(k);
            wstrb  = 4'hF;
            wvalid = 1'b1;
            modelWrite(16'h0600 + 16'(4 * k), wdata, wstrb);
            @(negedge clk);
        end
        wvalid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midrst_wready", 64'(wready), 64'd0);
        checkOutput("midrst_bvalid", 64'(bvalid), 64'd0);
        checkOutput("midrst_awready", 64'(awready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("awready_post_rst", 64'(awready), 64'd1);
        checkOutput("bvalid_post_rst", 64'(bvalid), 64'd0);
        checkTouched();
        fillBeats(2, 32'h70700000, 4'hF);
        applyStimulus(8'h9A, 16'h0610, 8'd1, 3'd2, 2'b01, 1);
        checkTouched();

        $display("[TB] random bursts");
        for (int n = 0; n < 12; n++) begin
            rId    = 8'($urandom);
            rBurst = 2'($urandom_range(0, 3));
            rSize  = 3'($urandom_range(0, 3));
            rAddr  = 16'($urandom);
            if (rBurst == 2'b10) begin
                rLen  = 8'((1 << $urandom_range(1, 3)) - 1);
                rAddr = rAddr & ~16'((1 << ((rSize > 3'd2) ? 2 : int'(rSize))) - 1);
            end else begin
                rLen = 8'($urandom_range(0, 7));
            end
            for (int k = 0; k <= int'(rLen); k++) begin
                bData[k] = $urandom;
                bStrb[k] = 4'($urandom);
                bLast[k] = (k == int'(rLen));
            end
            applyStimulus(rId, rAddr, rLen, rSize, rBurst, $urandom_range(0, 3));
            checkTouched();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
